// File: rtl/sl_fifo_write_arbiter.sv
// Round-robin scheduler sharing the core->APB async FIFO write port between four
// register sources. Each grant pushes {index[1:0], payload[31:0]} and is followed
// by a two-cycle gap so a granted requester can withdraw before the next decision.
module sl_fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_write_full,
  output logic [DATA_WIDTH+1:0]         fifo_write_data,
  output logic                          fifo_write_inc,
  output logic [CNT_WIDTH-1:0]          write_count,
  output logic                          busy
);

  // The 2-bit modifier carries the requester index, so four sources is a hard limit.
  localparam int unsigned IdxW = 2;

  typedef enum logic [2:0] {
    StIdle     = 3'b001,
    StWrite    = 3'b010,
    StWriteEnd = 3'b100
  } state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         last_q;
  logic [IdxW-1:0]         cand;
  logic [IdxW-1:0]         win_idx;
  logic                    win_vld;
  logic [NUM_REQ-1:0]      win_oh;
  logic [DATA_WIDTH-1:0]   win_data;

  // Round-robin pick: first active request searching upward from the one after last_q.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = last_q + IdxW'(i);
      if (!win_vld && req[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
    win_oh   = NUM_REQ'(1) << win_idx;
    win_data = req_data[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
  end

  // FSM with registered strobes; illegal encodings fall back to idle.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q         <= StIdle;
      last_q          <= IdxW'(NUM_REQ - 1);
      gnt             <= '0;
      fifo_write_inc  <= 1'b0;
      fifo_write_data <= '0;
      write_count     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arb_en && !fifo_write_full && win_vld) begin
            state_q         <= StWrite;
            fifo_write_data <= {win_idx, win_data};
            fifo_write_inc  <= 1'b1;
            gnt             <= win_oh;
            last_q          <= win_idx;
          end
        end
        StWrite: begin
          state_q         <= StWriteEnd;
          fifo_write_inc  <= 1'b0;
          gnt             <= '0;
          fifo_write_data <= '0;
          write_count     <= write_count + CNT_WIDTH'(1);
        end
        StWriteEnd: begin
          state_q <= StIdle;
        end
        default: begin
          state_q         <= StIdle;
          fifo_write_inc  <= 1'b0;
          gnt             <= '0;
          fifo_write_data <= '0;
        end
      endcase
    end
  end

  // Busy covers the write and gap cycles.
  always_comb begin
    busy = (state_q != StIdle);
  end

endmodule
